muxn_reg_arb: RTL

Parametrised N-channel, W-bit multiplexer with a registered output stage, valid/ready handshaking and two selection modes: externally selected, or round-robin arbitrated. It generalises the fixed 4:1 32-bit datapath select into a reusable channel merger. Typical uses are write-back source merging, multi-requester memory/MMIO ports and debug taps, where sources arrive on different cycles and back-pressure must be honoured.

---
 rtl/muxn_pkg.sv | 14 +
 rtl/muxn_reg_arb_rr_arbiter.sv | 29 ++
 rtl/muxn_reg_arb.sv | 89 ++++++++
 3 files changed

// File: rtl/muxn_pkg.sv
// Shared types and helpers for the muxn_reg_arb channel merger.
package muxn_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Modulo-n increment of a channel index (n-1 wraps to 0).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/muxn_reg_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first set request scanning from ptr upward, modulo NUM_CH.
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              found
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
            idx = SEL_W'(wrap_inc(int'(idx), NUM_CH));
        end
    end

endmodule

// File: rtl/muxn_reg_arb.sv
// N-channel registered multiplexer with valid/ready handshaking and
// external-select or round-robin channel selection.
module muxn_reg_arb
    import muxn_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  mode_e                        i_mode,
    input  logic [SEL_W-1:0]             i_sel,
    input  logic [NUM_CH-1:0]            i_valid,
    input  logic [NUM_CH-1:0][WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_ready,
    output logic                         o_valid,
    output logic [WIDTH-1:0]             o_data,
    output logic [SEL_W-1:0]             o_ch,
    input  logic                         i_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_found;
    logic             sel_found;
    logic [SEL_W-1:0] grant;
    logic             found;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [SEL_W-1:0] ch_p1;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req   (i_valid),
        .ptr   (ptr),
        .grant (rr_grant),
        .found (rr_found)
    );

    // An out-of-range select matches no channel, so it never grants.
    always_comb begin
        sel_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_sel == SEL_W'(k)) sel_found = i_valid[k];
        end
    end

    assign load_en = !vld_p1 || i_ready;
    assign grant   = (i_mode == MODE_RR) ? rr_grant : i_sel;
    assign found   = (i_mode == MODE_RR) ? rr_found : sel_found;
    assign xfer    = load_en && found;

    always_comb begin
        o_ready    = '0;
        grant_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant == SEL_W'(k)) begin
                o_ready[k] = xfer && !i_reset;
                grant_data = i_data[k];
            end
        end
    end

    // Stage p1: output register; ptr advances past every granted channel.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= grant_data;
            ch_p1   <= grant;
            ptr     <= SEL_W'(wrap_inc(int'(grant), NUM_CH));
        end else if (load_en) begin
            vld_p1  <= 1'b0;
        end
    end

    assign o_valid = vld_p1;
    assign o_data  = data_p1;
    assign o_ch    = ch_p1;

endmodule
